// File: rtl/lab6_switch_encoder_master_pkg.sv
// lab6_pkg: shared code constants, FSM encoding and the switch encoder used by RTL and bench.
// LAB6_PRIORITY_EN: when defined, multi-hot switches encode to the lowest set index instead of INVALID.
package lab6_pkg;

  localparam int MAX_SW_W = 32;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  function automatic int invalid_code(input int sw_w);
    return sw_w;
  endfunction

  function automatic int off_code(input int sw_w);
    return sw_w + 1;
  endfunction

  localparam int DEF_SW_W    = 8;
  localparam int DEF_INVALID = invalid_code(DEF_SW_W);
  localparam int DEF_OFF     = off_code(DEF_SW_W);

  function automatic int onehot_encode(input logic [MAX_SW_W-1:0] sw, input int sw_w);
    int ones;
    int lowest;
    int result;
    ones   = 0;
    lowest = 0;
    // Scan downwards so the last hit left in 'lowest' is the lowest set index.
    for (int i = MAX_SW_W - 1; i >= 0; i--) begin
      if (i < sw_w && sw[i]) begin
        ones   = ones + 1;
        lowest = i;
      end
    end
    if (ones == 0) begin
      result = off_code(sw_w);
    end else begin
`ifdef LAB6_PRIORITY_EN
      result = lowest;
`else
      result = (ones == 1) ? lowest : invalid_code(sw_w);
`endif
    end
    return result;
  endfunction

endpackage

// File: rtl/lab6_switch_encoder_master_if.sv
// Valid/ack handshake between the switch encoder master and the LED decoder slave.
interface lab6_switch_encoder_master_if #(
  parameter int CODE_W = 4
);
  logic [CODE_W-1:0] data_out;
  logic              data_valid;
  logic              data_ack;

  modport master (output data_out, output data_valid, input data_ack);
  modport slave  (input data_out, input data_valid, output data_ack);
endinterface

// File: rtl/lab6_switch_encoder_master_sync_debounce.sv
// lab6_sync_debounce: 2-flop switch synchroniser plus a candidate/counter stability qualifier.
module lab6_sync_debounce
  import lab6_pkg::*;
#(
  parameter int SW_W       = 8,
  parameter int CODE_W     = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SW_W-1:0]   i_sw,
  output logic [SW_W-1:0]   o_swSync,
  input  logic [CODE_W-1:0] i_enc,
  output logic [CODE_W-1:0] o_cand,
  output logic              o_stable
);

  localparam int                CNT_W   = $clog2(STABLE_CYC);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYC - 1);
  localparam logic [CODE_W-1:0] OFF     = CODE_W'(off_code(SW_W));

  logic [SW_W-1:0]   r_meta;
  logic [SW_W-1:0]   r_swSync;
  logic [CODE_W-1:0] r_cand;
  logic [CNT_W-1:0]  r_cnt;

  // Any change of the encoded code restarts qualification; the counter saturates once stable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_meta   <= '0;
      r_swSync <= '0;
      r_cand   <= OFF;
      r_cnt    <= '0;
    end else begin
      r_meta   <= i_sw;
      r_swSync <= r_meta;
      if (i_enc != r_cand) begin
        r_cand <= i_enc;
        r_cnt  <= '0;
      end else if (r_cnt < CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_swSync = r_swSync;
  assign o_cand   = r_cand;
  assign o_stable = (i_enc == r_cand) && (r_cnt == CNT_MAX);

endmodule

// File: rtl/lab6_switch_encoder_master.sv
// lab6_switch_encoder_master: encodes a debounced one-hot switch bank and sends each new code to the slave.
// Multi-hot behaviour is selected by LAB6_PRIORITY_EN inside lab6_pkg::onehot_encode.
module lab6_switch_encoder_master
  import lab6_pkg::*;
#(
  parameter int SW_W       = 8,
  parameter int CODE_W     = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SW_W-1:0]              sw,
  output logic [CODE_W-1:0]            data_look,
  lab6_switch_encoder_master_if.master bus
);

  localparam logic [CODE_W-1:0] OFF = CODE_W'(off_code(SW_W));

  if ((2 ** CODE_W) < (SW_W + 2)) begin : gCodeWidthCheck
    $error("lab6_switch_encoder_master: CODE_W too narrow for SW_W+2 codes");
  end
  if (SW_W < 2 || SW_W > MAX_SW_W) begin : gSwWidthCheck
    $error("lab6_switch_encoder_master: SW_W out of range");
  end
  if (STABLE_CYC < 2) begin : gStableCheck
    $error("lab6_switch_encoder_master: STABLE_CYC must be at least 2");
  end

  logic [SW_W-1:0]   w_swSync;
  logic [CODE_W-1:0] w_enc;
  logic [CODE_W-1:0] w_cand;
  logic              w_stable;
  state_t            r_state;
  logic [CODE_W-1:0] r_look;

  assign w_enc = CODE_W'(onehot_encode(MAX_SW_W'(w_swSync), SW_W));

  lab6_sync_debounce #(
    .SW_W       (SW_W),
    .CODE_W     (CODE_W),
    .STABLE_CYC (STABLE_CYC)
  ) u_syncDebounce (
    .clk      (clk),
    .rst      (rst),
    .i_sw     (sw),
    .o_swSync (w_swSync),
    .i_enc    (w_enc),
    .o_cand   (w_cand),
    .o_stable (w_stable)
  );

  // Codes qualified while busy wait in the debouncer; only the newest one launches from IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_look         <= OFF;
      bus.data_out   <= OFF;
      bus.data_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_stable && (w_cand != r_look)) begin
            bus.data_out   <= w_cand;
            bus.data_valid <= 1'b1;
            r_look         <= w_cand;
            r_state        <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (bus.data_ack) begin
            bus.data_valid <= 1'b0;
            r_state        <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_look = r_look;

endmodule

// File: tb/tb_lab6_switch_encoder_master.sv
// Bench for lab6_switch_encoder_master: directed scenarios plus randomized switches against a cycle model.
module tb_lab6_switch_encoder_master;
  import lab6_pkg::*;

  localparam int SW_W       = 8;
  localparam int CODE_W     = 4;
  localparam int STABLE_CYC = 4;
  localparam int OFF_C      = SW_W + 1;
  localparam int INVALID_C  = SW_W;
`ifdef LAB6_PRIORITY_EN
  localparam int MULTI_05   = 0;
  localparam int MULTI_06   = 1;
`else
  localparam int MULTI_05   = INVALID_C;
  localparam int MULTI_06   = INVALID_C;
`endif

  logic              clk;
  logic              rst;
  logic [SW_W-1:0]   sw;
  logic [CODE_W-1:0] dataLook;

  lab6_switch_encoder_master_if #(.CODE_W(CODE_W)) bus ();

  lab6_switch_encoder_master #(
    .SW_W       (SW_W),
    .CODE_W     (CODE_W),
    .STABLE_CYC (STABLE_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .data_look (dataLook),
    .bus       (bus)
  );

  int checks      = 0;
  int failures    = 0;
  int edgeCount   = 0;
  int lastAckEdge = -1;
  bit autoAck     = 1'b0;
  bit idleAckEn   = 1'b0;
  int ackDelay    = 0;

  // Reference model state: what the outputs must be after the most recent edge.
  bit         mArmed = 1'b0;
  logic [7:0] mP1, mP2;
  int         mEnc, mRun, mOut, mLook;
  bit         mValid;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int modelEncode(input logic [7:0] s);
    int result;
    if (s == 8'h00) result = OFF_C;
    else if ((s & (s - 8'd1)) == 8'h00) result = $clog2(s);
    else begin
`ifdef LAB6_PRIORITY_EN
      logic [7:0] low;
      low    = s & (~s + 8'd1);
      result = $clog2(low);
`else
      result = INVALID_C;
`endif
    end
    return result;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] s, input int hold);
    sw = s;
    tick(hold);
  endtask

  task automatic waitValid(input string name, input int bound, output int edges);
    edges = 0;
    while (edges < bound && !bus.data_valid) begin
      tick(1);
      edges++;
    end
    checkOutput(name, int'(bus.data_valid), 1);
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (n < 30 && bus.data_valid) begin
      tick(1);
      n++;
    end
    checkOutput(name, int'(bus.data_valid), 0);
    tick(2);
  endtask

  // Model: a code is stable once the synchronised encoding has held for STABLE_CYC+1 cycles;
  // reset counts as one cycle of OFF already seen.
  initial begin
    int newEnc;
    bit stableNow;
    forever begin
      @(posedge clk);
      edgeCount++;
      if (!rst) begin
        mP1 = 8'h00; mP2 = 8'h00;
        mEnc = OFF_C; mRun = 2;
        mOut = OFF_C; mLook = OFF_C; mValid = 1'b0;
        mArmed = 1'b1;
      end else if (mArmed) begin
        stableNow = (mRun >= STABLE_CYC + 1);
        if (mValid) begin
          if (bus.data_ack) mValid = 1'b0;
        end else if (stableNow && mEnc != mLook) begin
          mOut = mEnc; mLook = mEnc; mValid = 1'b1;
        end
        mP2 = mP1;
        mP1 = sw;
        newEnc = modelEncode(mP2);
        if (newEnc == mEnc) begin
          if (mRun < 1000) mRun++;
        end else begin
          mEnc = newEnc;
          mRun = 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mArmed) begin
        checkOutput("cyc_data_out", int'(bus.data_out), mOut);
        checkOutput("cyc_data_valid", int'(bus.data_valid), int'(mValid));
        checkOutput("cyc_data_look", int'(dataLook), mLook);
      end
    end
  end

  // Slave: acks ackDelay cycles after seeing valid, optionally pulses stray acks while idle.
  initial begin
    int waitCnt;
    waitCnt = 0;
    bus.data_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.data_ack) begin
        bus.data_ack = 1'b0;
        lastAckEdge  = edgeCount;
      end else if (bus.data_valid && autoAck) begin
        if (waitCnt >= ackDelay) begin
          bus.data_ack = 1'b1;
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end else if (!bus.data_valid) begin
        waitCnt = 0;
        if (idleAckEn && $urandom_range(0, 7) == 0) bus.data_ack = 1'b1;
      end
    end
  end

  initial begin
    int edges;
    int fallEdge;
    int rises;
    int riseCode;
    bit prevValid;
    logic [7:0] s;
    logic [7:0] one;
    int hold;

    checkOutput("pkg_enc_bit4", onehot_encode(32'h10, SW_W), 4);
    checkOutput("pkg_enc_zero", onehot_encode(32'h00, SW_W), OFF_C);
    checkOutput("pkg_enc_multi", onehot_encode(32'h05, SW_W), MULTI_05);
    checkOutput("model_enc_bit7", modelEncode(8'h80), 7);
    checkOutput("model_enc_multi", modelEncode(8'h06), MULTI_06);

    // Reset held three cycles with a switch already on.
    rst = 1'b0;
    sw  = 8'h10;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("rst_data_out", int'(bus.data_out), OFF_C);
      checkOutput("rst_data_look", int'(dataLook), OFF_C);
      checkOutput("rst_data_valid", int'(bus.data_valid), 0);
    end
    rst = 1'b1;
    autoAck = 1'b1;
    ackDelay = 0;
    waitValid("post_rst_valid", 30, edges);
    checkOutput("post_rst_code", int'(bus.data_out), 4);
    waitIdle("post_rst_idle");

    // Latency of a single clean change and drop on ack.
    ackDelay = 2;
    sw = 8'h04;
    waitValid("t2_valid", 30, edges);
    checkOutput("t2_latency_edges", edges, STABLE_CYC + 3);
    checkOutput("t2_code", int'(bus.data_out), 2);
    while (bus.data_valid && edges < 60) begin
      tick(1);
      edges++;
    end
    fallEdge = edgeCount;
    checkOutput("t2_drop_on_ack_edge", fallEdge, lastAckEdge);
    tick(2);

    // Multi-hot switches.
    ackDelay = 1;
    sw = 8'h05;
    waitValid("t3_valid", 30, edges);
    checkOutput("t3_multi_code", int'(bus.data_out), MULTI_05);
    waitIdle("t3_idle");

    // Return to OFF, then a short pulse must not produce a transfer.
    sw = 8'h00;
    waitValid("t4_off_valid", 30, edges);
    checkOutput("t4_off_code", int'(bus.data_out), OFF_C);
    waitIdle("t4_off_idle");
    applyStimulus(8'h01, 2);
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'h00, 1);
      if (bus.data_valid) rises++;
    end
    checkOutput("t4_glitch_valid_cycles", rises, 0);

    // Changes while waiting for ack: hold code 3, then only the newest code goes out.
    autoAck = 1'b0;
    sw = 8'h08;
    waitValid("t5_valid", 30, edges);
    checkOutput("t5_first_code", int'(bus.data_out), 3);
    sw = 8'h20;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) sw = 8'h40;
      tick(1);
      checkOutput("t5_hold_code", int'(bus.data_out), 3);
    end
    autoAck = 1'b1;
    ackDelay = 0;
    prevValid = bus.data_valid;
    rises = 0;
    riseCode = -1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (bus.data_valid && !prevValid) begin
        rises++;
        riseCode = int'(bus.data_out);
      end
      prevValid = bus.data_valid;
    end
    checkOutput("t5_transfer_count", rises, 1);
    checkOutput("t5_transfer_code", riseCode, 6);

    // Reset in the middle of a handshake, then resend of the current switch.
    autoAck = 1'b0;
    sw = 8'h01;
    waitValid("t6_valid", 30, edges);
    checkOutput("t6_code", int'(bus.data_out), 0);
    rst = 1'b0;
    tick(1);
    checkOutput("t6_rst_valid", int'(bus.data_valid), 0);
    checkOutput("t6_rst_data_out", int'(bus.data_out), OFF_C);
    checkOutput("t6_rst_look", int'(dataLook), OFF_C);
    rst = 1'b1;
    autoAck = 1'b1;
    waitValid("t6_resend_valid", 30, edges);
    checkOutput("t6_resend_code", int'(bus.data_out), 0);
    waitIdle("t6_idle");

    // Randomized switches, ack delays, stray idle acks and occasional resets.
    idleAckEn = 1'b1;
    one = 8'h01;
    for (int it = 0; it < 300; it++) begin
      ackDelay = int'($urandom_range(0, 3));
      hold = int'($urandom_range(1, 12));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: s = one << $urandom_range(0, 7);
        5:             s = 8'h00;
        6, 7:          s = 8'($urandom_range(0, 255));
        default: begin
          s = one << $urandom_range(0, 7);
          hold = 1;
        end
      endcase
      applyStimulus(s, hold);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b0;
        tick(int'($urandom_range(1, 2)));
        rst = 1'b1;
      end
    end
    idleAckEn = 1'b0;
    tick(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
